iter_sequencer: RTL and testbench
=================================

Name: iter_sequencer

Overview:
Parametrised iteration sequencer for multi-cycle arithmetic units (multiplier/divider datapaths). It is the successor to the fixed 7-bit free-running step counter. It adds a start/done handshake, a run-time iteration count, stall and abort controls, and explicit load/step/last/done strobes. It sits between the issue logic and a multi-cycle datapath: it sequences operand load, N iteration steps and a completion pulse.

Parameters:
WIDTH, 7, width of iteration counter and iteration-count input.
DEFAULT_ITERS, 32, iteration count used when iters input is all-zeros and USE_DEFAULT=1.
USE_DEFAULT, 1, 1: iters==0 selects DEFAULT_ITERS; 0: iters==0 means zero iterations.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
start  input  1  request new operation; sampled only in IDLE or DONE
iters  input  WIDTH  iteration count N, latched on accepted start
hold  input  1  stall; freezes iteration progress while in RUN
abort  input  1  synchronous cancel, returns to IDLE without done
busy  output  1  high in LOAD and RUN
load  output  1  one-cycle operand-load strobe (LOAD state)
step  output  1  datapath iteration enable (RUN and not hold)
last  output  1  high in RUN when count == N-1
done  output  1  one-cycle completion pulse (DONE state)
count  output  WIDTH  current iteration index

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (reset=0). While reset=0, state=IDLE, count=0, latched N=0, and busy/load/step/last/done=0.
- All outputs are decoded from registered state and count (Moore). There is no combinational path from any input to any output, except step and last. Both are gated by hold.
- States:
  - IDLE: accepted start -> LOAD. Latch N = iters; if USE_DEFAULT and iters==0, N = DEFAULT_ITERS.
  - LOAD: lasts 1 cycle. load=1, count=0. Next state is RUN, or DONE if N==0.
  - RUN: step=1 when hold=0. On each edge with hold=0, count increments. The edge with count==N-1 and hold=0 moves to DONE with count=N. With hold=1, count and state are frozen, and step=0 and last=0.
  - DONE: lasts 1 cycle. done=1. start in DONE is accepted (back-to-back) -> LOAD, with new N latched. Otherwise -> IDLE.
- Latency: start accepted at edge E gives load high in cycle E+1. step is high in cycles E+2..E+N+1 when there are no holds. done is high in cycle E+N+2. Each hold cycle adds one cycle.
- count holds its last value (N) in IDLE. It is cleared only on entry to LOAD or by reset.
- start is ignored in LOAD and RUN. iters changes after acceptance have no effect.
- abort has priority over start and hold in every state. The next state is IDLE, done is not asserted, and count holds. Abort in DONE suppresses nothing: done has already been asserted that cycle, and the next state is IDLE.
- N = 2^WIDTH-1 is legal. count never exceeds N, so it never wraps.
- Asynchronous reset mid-operation returns everything to reset values immediately. No done is produced.

Test Plan:
- Basic run: reset release, iters=5, start pulse -> load in cycle 1, step in cycles 2-6 with count 0..4, last in cycle 6 (count=4), done in cycle 7 with count=5, busy falling with done.
- Default count: USE_DEFAULT=1, iters=0, start -> exactly 32 step cycles, done with count=32. USE_DEFAULT=0, iters=0 -> LOAD then DONE directly, zero step cycles.
- Hold: iters=4, hold=1 for 3 cycles when count=2 -> count stays 2, step=0 and last=0 during the hold, done delayed by exactly 3 cycles (cycle 9).
- Back-to-back and ignore: start held high continuously with iters=3 -> done, then load on the following cycle. A start pulse mid-RUN is ignored, and changing iters mid-RUN does not alter N.
- Abort: abort asserted at count=1 of a 6-iteration run -> IDLE next cycle, done never pulses, busy=0, count held at 1. abort together with start in IDLE -> remains IDLE.
- Async reset: reset asserted low mid-RUN, between clock edges -> all outputs 0 immediately. After release, a new start with iters=2 completes normally.

Source files
------------

// File: rtl/iter_sequencer.sv
// Iteration sequencer for multi-cycle datapaths: start/done handshake, run-time
// iteration count, hold/abort, and load/step/last/done strobes.
module iter_sequencer #(
    parameter int unsigned WIDTH         = 7,
    parameter int unsigned DEFAULT_ITERS = 32,
    parameter int unsigned USE_DEFAULT   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] iters,
    input  logic             hold,
    input  logic             abort,
    output logic             busy,
    output logic             load,
    output logic             step,
    output logic             last,
    output logic             done,
    output logic [WIDTH-1:0] count
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] n_q;
    logic             accept_c;
    logic             at_last_c;
    logic             zero_iters_c;

    assign accept_c     = start && !abort && ((state == S_IDLE) || (state == S_DONE));
    assign at_last_c    = (count == (n_q - WIDTH'(1)));
    assign zero_iters_c = (iters == '0);

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides everything
    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_LOAD;
                S_LOAD:  state_nxt = (n_q == '0) ? S_DONE : S_RUN;
                S_RUN:   if (!hold && at_last_c) state_nxt = S_DONE;
                S_DONE:  state_nxt = start ? S_LOAD : S_IDLE;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Iteration count and latched N; count only clears on entry to LOAD
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_q   <= '0;
            count <= '0;
        end else begin
            if (accept_c) begin
                n_q   <= ((USE_DEFAULT != 0) && zero_iters_c) ? WIDTH'(DEFAULT_ITERS) : iters;
                count <= '0;
            end else if ((state == S_RUN) && !hold && !abort) begin
                count <= count + WIDTH'(1);
            end
        end
    end

    // Moore decode; only step and last see hold directly
    always_comb begin
        busy = 1'b0;
        load = 1'b0;
        step = 1'b0;
        last = 1'b0;
        done = 1'b0;
        case (state)
            S_LOAD: begin
                busy = 1'b1;
                load = 1'b1;
            end
            S_RUN: begin
                busy = 1'b1;
                step = !hold;
                last = !hold && at_last_c;
            end
            S_DONE:  done = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_iter_sequencer.sv
// Randomised scoreboard bench for iter_sequencer, plus directed checks on a
// USE_DEFAULT=0 narrow instance and on asynchronous reset.
module tb_iter_sequencer;

    localparam int W   = 7;
    localparam int DEF = 32;
    localparam int NW  = 3;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic         start = 1'b0;
    logic         hold  = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] iters = '0;
    logic         busy, load, step, last, done;
    logic [W-1:0] count;

    logic          nd_start = 1'b0;
    logic          nd_hold  = 1'b0;
    logic          nd_abort = 1'b0;
    logic [NW-1:0] nd_iters = '0;
    logic          nd_busy, nd_load, nd_step, nd_last, nd_done;
    logic [NW-1:0] nd_count;

    iter_sequencer #(.WIDTH(W), .DEFAULT_ITERS(DEF), .USE_DEFAULT(1)) dut (
        .clock(clock), .reset(reset), .start(start), .iters(iters), .hold(hold),
        .abort(abort), .busy(busy), .load(load), .step(step), .last(last),
        .done(done), .count(count)
    );

    iter_sequencer #(.WIDTH(NW), .DEFAULT_ITERS(5), .USE_DEFAULT(0)) dut_nd (
        .clock(clock), .reset(reset), .start(nd_start), .iters(nd_iters), .hold(nd_hold),
        .abort(nd_abort), .busy(nd_busy), .load(nd_load), .step(nd_step), .last(nd_last),
        .done(nd_done), .count(nd_count)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    typedef struct {
        int n;
        bit aborted;
        int exp_count;
        int exp_end;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   passes = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic int eff_n(input int it);
        return (it == 0) ? DEF : it;
    endfunction

    task automatic advance();
        @(posedge clock);
        #1;
    endtask

    // Monitor: pops the scoreboard at every end of operation (done or abort)
    initial begin : monitor
        bit   in_op;
        int   steps;
        int   end_count;
        exp_t cur;
        in_op = 1'b0;
        steps = 0;
        end_count = 0;
        forever begin
            @(negedge clock);
            if (!mon_en) begin
                in_op = 1'b0;
                end_count = 0;
            end else if (!in_op) begin
                if (load) begin
                    chk("load_expected", longint'(sbq.size() > 0), 1);
                    if (sbq.size() > 0) begin
                        cur   = sbq[0];
                        in_op = 1'b1;
                        steps = 0;
                        chk("load_count", longint'(count), 0);
                        chk("load_busy", longint'(busy), 1);
                    end
                end else begin
                    chk("idle_outputs", longint'({busy, step, last, done, count}),
                        longint'({4'b0, W'(end_count)}));
                end
            end else begin
                if (step) begin
                    chk("step_count", longint'(count), longint'(steps));
                    chk("step_hold", longint'(hold), 0);
                    chk("last", longint'(last), longint'(int'(count) == cur.n - 1));
                    steps++;
                end else begin
                    chk("last_without_step", longint'(last), 0);
                end
                if (done || !busy) begin
                    void'(sbq.pop_front());
                    in_op = 1'b0;
                    end_count = int'(count);
                    chk("end_is_done", longint'(done), longint'(!cur.aborted));
                    chk("end_cycle", longint'(cyc), longint'(cur.exp_end));
                    if (done) begin
                        chk("done_count", longint'(count), longint'(cur.n));
                        chk("done_steps", longint'(steps), longint'(cur.n));
                        chk("done_busy", longint'(busy), 0);
                    end else begin
                        chk("abort_count", longint'(count), longint'(cur.exp_count));
                    end
                end
            end
        end
    end

    // Issue one operation starting in the current cycle; returns at the start of
    // the cycle following the run (the DONE cycle, or IDLE after an abort).
    task automatic run_op(input int it, input bit rnd, output bit ended_done);
        int   n;
        int   k;
        int   i;
        int   ab_idx;
        int   c0;
        bit   ab_load;
        bit   hb;
        bit   h[$];
        exp_t e;
        n  = eff_n(it);
        k  = 0;
        i  = 0;
        c0 = cyc;
        ab_idx = -1;
        ab_load = rnd && ($urandom_range(0, 19) == 0);
        if (rnd && $urandom_range(0, 5) == 0) ab_idx = int'($urandom_range(0, n + 1));
        e.n = n;
        e.aborted = 1'b0;
        e.exp_count = n;
        if (ab_load) begin
            e.aborted = 1'b1;
            e.exp_count = 0;
            e.exp_end = c0 + 2;
        end else if (n == 0) begin
            e.exp_end = c0 + 2;
        end else begin
            while (k < n) begin
                if (i == ab_idx) begin
                    e.aborted = 1'b1;
                    e.exp_count = k;
                    break;
                end
                hb = rnd && ($urandom_range(0, 3) == 0);
                h.push_back(hb);
                if (!hb) k++;
                i++;
            end
            e.exp_end = e.aborted ? c0 + 3 + i : c0 + 2 + i;
        end
        sbq.push_back(e);

        start = 1'b1;
        iters = W'(it);
        abort = 1'b0;
        hold  = rnd && $urandom_range(0, 1) == 1;
        advance();
        start = rnd && $urandom_range(0, 2) == 0;
        iters = rnd ? W'($urandom) : iters;
        abort = ab_load;
        hold  = rnd && $urandom_range(0, 1) == 1;
        advance();
        if (!ab_load) begin
            foreach (h[j]) begin
                start = rnd && $urandom_range(0, 3) == 0;
                iters = rnd ? W'($urandom) : iters;
                hold  = h[j];
                abort = 1'b0;
                advance();
            end
            if (e.aborted) begin
                start = $urandom_range(0, 1) == 1;
                hold  = $urandom_range(0, 1) == 1;
                abort = 1'b1;
                advance();
            end
        end
        start = 1'b0;
        hold  = 1'b0;
        abort = 1'b0;
        ended_done = !e.aborted;
    endtask

    task automatic idle_cycle(input bit try_start);
        start = try_start;
        abort = try_start;
        hold  = $urandom_range(0, 1) == 1;
        iters = W'($urandom);
        advance();
        start = 1'b0;
        abort = 1'b0;
        hold  = 1'b0;
    endtask

    task automatic nd_run(input int it, input int exp_steps);
        int steps;
        int c_load;
        nd_start = 1'b1;
        nd_iters = NW'(it);
        advance();
        nd_start = 1'b0;
        c_load = cyc;
        chk("nd_load", longint'(nd_load), 1);
        chk("nd_load_count", longint'(nd_count), 0);
        steps = 0;
        advance();
        for (int c = 0; c < 20 && !nd_done; c++) begin
            if (nd_step) steps++;
            advance();
        end
        chk("nd_done_reached", longint'(nd_done), 1);
        chk("nd_steps", longint'(steps), longint'(exp_steps));
        chk("nd_done_count", longint'(nd_count), longint'(exp_steps));
        chk("nd_latency", longint'(cyc - c_load), longint'(exp_steps + 1));
        advance();
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        bit prev_done;
        int it;
        bit rnd;
        int r;
        prev_done = 1'b0;
        #12;
        chk("reset_outputs", longint'({busy, load, step, last, done, count}), 0);
        chk("reset_outputs_nd", longint'({nd_busy, nd_load, nd_step, nd_last, nd_done, nd_count}), 0);
        advance();
        reset = 1'b1;
        mon_en = 1'b1;
        advance();

        for (int op = 0; op < 60; op++) begin
            rnd = (op >= 4);
            case (op)
                0: it = 5;
                1: it = 0;
                2: it = 127;
                3: it = 4;
                default: begin
                    r = int'($urandom_range(0, 9));
                    if (r == 0) it = 0;
                    else if (r == 1) it = 127;
                    else it = int'($urandom_range(1, 12));
                end
            endcase
            if (!(prev_done && rnd && $urandom_range(0, 1) == 1)) begin
                if (prev_done) idle_cycle($urandom_range(0, 2) == 0);
                repeat ($urandom_range(0, 2)) idle_cycle($urandom_range(0, 3) == 0);
            end
            run_op(it, rnd, prev_done);
        end
        idle_cycle(1'b0);
        repeat (3) idle_cycle(1'b0);
        chk("queue_drained", longint'(sbq.size()), 0);

        nd_run(0, 0);
        nd_run(7, 7);
        nd_run(3, 3);

        // Asynchronous reset in the middle of a run
        mon_en = 1'b0;
        advance();
        sbq.delete();
        start = 1'b1;
        iters = W'(10);
        advance();
        start = 1'b0;
        repeat (4) advance();
        chk("pre_reset_busy", longint'(busy), 1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_reset_outputs", longint'({busy, load, step, last, done, count}), 0);
        #2;
        reset = 1'b1;
        advance();
        advance();
        mon_en = 1'b1;
        advance();
        run_op(2, 1'b0, prev_done);
        idle_cycle(1'b0);
        repeat (3) idle_cycle(1'b0);
        chk("post_reset_drained", longint'(sbq.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
